// File: rtl/timer_display_mux_if.sv
// Bundles the Timer digit inputs and the 7-segment display lines.
// The master side is the Timer/board environment; the slave side is the display mux.
interface timer_display_mux_if;
  logic       enable;
  logic       paused;
  logic [3:0] minutes0;
  logic [3:0] seconds1;
  logic [3:0] seconds0;
  logic [6:0] segments;
  logic [2:0] anode;
  logic       dp;

  modport master (
    output enable, paused, minutes0, seconds1, seconds0,
    input  segments, anode, dp
  );

  modport slave (
    input  enable, paused, minutes0, seconds1, seconds0,
    output segments, anode, dp
  );
endinterface

// File: rtl/timer_display_mux.sv
// Time-multiplexed M:SS driver for a common-anode 3-digit 7-segment display.
// Digits are snapshotted once per frame, and the whole display blinks while paused.
module timer_display_mux #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic                clk,
  input logic                reset,
  timer_display_mux_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    DIGIT_S0 = 2'd0,
    DIGIT_S1 = 2'd1,
    DIGIT_M0 = 2'd2
  } digit_t;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_t;

  logic [PW-1:0] prescaler;
  digit_t        index;
  logic [3:0]    snap_m0;
  logic [3:0]    snap_s1;
  logic [3:0]    snap_s0;
  logic [BW-1:0] blink_count;
  phase_t        phase;

  logic          tick;
  logic          frame_end;
  logic          lit;
  logic [3:0]    digit_value;
  logic [6:0]    segments_next;
  logic [2:0]    anode_next;
  logic          dp_next;

  function automatic logic [6:0] decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  assign tick      = (prescaler == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (index == DIGIT_M0);

  // Releasing pause lights the display on the very next load, not a frame later.
  assign lit = bus.enable && ((phase == PHASE_ON) || !bus.paused);

  always_comb begin
    digit_value   = snap_s0;
    segments_next = 7'h7F;
    anode_next    = 3'b111;
    dp_next       = 1'b1;
    case (index)
      DIGIT_S0: digit_value = snap_s0;
      DIGIT_S1: digit_value = snap_s1;
      DIGIT_M0: digit_value = snap_m0;
      default:  digit_value = snap_s0;
    endcase
    if (lit) begin
      segments_next = decode(digit_value);
      case (index)
        DIGIT_S0: anode_next = 3'b110;
        DIGIT_S1: anode_next = 3'b101;
        DIGIT_M0: anode_next = 3'b011;
        default:  anode_next = 3'b111;
      endcase
      dp_next = (index != DIGIT_M0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler    <= '0;
      index        <= DIGIT_S0;
      snap_m0      <= 4'd0;
      snap_s1      <= 4'd0;
      snap_s0      <= 4'd0;
      blink_count  <= '0;
      phase        <= PHASE_ON;
      bus.segments <= 7'h7F;
      bus.anode    <= 3'b111;
      bus.dp       <= 1'b1;
    end else begin
      bus.segments <= segments_next;
      bus.anode    <= anode_next;
      bus.dp       <= dp_next;

      if (tick) begin
        prescaler <= '0;
        case (index)
          DIGIT_S0: index <= DIGIT_S1;
          DIGIT_S1: index <= DIGIT_M0;
          default:  index <= DIGIT_S0;
        endcase
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      // Inputs sampled on the frame-end edge are shown from digit 0 of the next frame.
      if (frame_end) begin
        snap_m0 <= bus.minutes0;
        snap_s1 <= bus.seconds1;
        snap_s0 <= bus.seconds0;
      end

      if (!bus.paused) begin
        blink_count <= '0;
        phase       <= PHASE_ON;
      end else if (frame_end) begin
        if (blink_count == BW'(BLINK_FRAMES - 1)) begin
          blink_count <= '0;
          phase       <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
          blink_count <= blink_count + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_display_mux.sv
// Directed bench for timer_display_mux with SCAN_DIV=4, BLINK_FRAMES=2.
// A frame is 12 edges; pos tracks the edge position within the frame after reset release.
module tb_timer_display_mux;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   pos;
  int   edge_count;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  timer_display_mux_if bus ();

  timer_display_mux #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    bus.minutes0 = m0;
    bus.seconds1 = s1;
    bus.seconds0 = s0;
  endtask

  // Each edge shows digit pos/4 of the frame; e0/e1/e2 are the expected patterns for digits 0/1/2.
  task automatic checkCycles(input int n, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic lit);
    int         idx;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;
    logic       exp_dp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_count++;
      idx = pos / 4;
      pos = (pos + 1) % 12;
      if (lit) begin
        exp_seg = (idx == 0) ? e0 : (idx == 1) ? e1 : e2;
        exp_an  = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
        exp_dp  = (idx == 2) ? 1'b0 : 1'b1;
      end else begin
        exp_seg = 7'h7F;
        exp_an  = 3'b111;
        exp_dp  = 1'b1;
      end
      checkOutput($sformatf("segments@%0d", edge_count), {25'd0, bus.segments}, {25'd0, exp_seg});
      checkOutput($sformatf("anode@%0d", edge_count), {29'd0, bus.anode}, {29'd0, exp_an});
      checkOutput($sformatf("dp@%0d", edge_count), {31'd0, bus.dp}, {31'd0, exp_dp});
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_segments"}, {25'd0, bus.segments}, 32'h7F);
    checkOutput({tag, "_anode"}, {29'd0, bus.anode}, 32'h7);
    checkOutput({tag, "_dp"}, {31'd0, bus.dp}, 32'h1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pos          = 0;
    edge_count   = 0;
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.paused   = 1'b0;
    applyStimulus(4'd3, 4'd4, 4'd5);

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");

    // First frame shows 0:00 while 3:45 is captured at its final edge.
    reset = 1'b0;
    pos   = 0;
    checkCycles(12, SEG_0, SEG_0, SEG_0, 1'b1);

    // Change to 4:00 mid-frame; the current frame keeps showing 3:45.
    checkCycles(6, SEG_5, SEG_4, SEG_3, 1'b1);
    applyStimulus(4'd4, 4'd0, 4'd0);
    checkCycles(6, SEG_5, SEG_4, SEG_3, 1'b1);

    // Invalid BCD on seconds0 appears one frame later as a dash.
    applyStimulus(4'd4, 4'd0, 4'hC);
    checkCycles(12, SEG_0, SEG_0, SEG_4, 1'b1);
    checkCycles(12, SEG_DASH, SEG_0, SEG_4, 1'b1);

    // Pause from a frame boundary: two frames lit, two dark, repeating.
    bus.paused = 1'b1;
    checkCycles(24, SEG_DASH, SEG_0, SEG_4, 1'b1);
    checkCycles(24, SEG_DASH, SEG_0, SEG_4, 1'b0);
    checkCycles(24, SEG_DASH, SEG_0, SEG_4, 1'b1);
    checkCycles(6, SEG_DASH, SEG_0, SEG_4, 1'b0);
    bus.paused = 1'b0;
    checkCycles(6, SEG_DASH, SEG_0, SEG_4, 1'b1);

    // Disable blanks everything while scanning continues underneath.
    bus.enable = 1'b0;
    checkCycles(8, SEG_DASH, SEG_0, SEG_4, 1'b0);
    bus.enable = 1'b1;
    checkCycles(4, SEG_DASH, SEG_0, SEG_4, 1'b1);

    // Reset mid-frame restarts scanning at digit 0 with a cleared snapshot.
    checkCycles(5, SEG_DASH, SEG_0, SEG_4, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("midreset");
    reset = 1'b0;
    pos   = 0;
    checkCycles(12, SEG_0, SEG_0, SEG_0, 1'b1);
    checkCycles(4, SEG_DASH, SEG_0, SEG_4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
